// File: rtl/mips_pkg.sv
// Shared loader protocol constants and FSM state encoding.
// StChk exists only when PROG_LOADER_CHECKSUM_EN is defined.
package mips_pkg;

    localparam int unsigned LenBits      = 16;
    localparam int unsigned BytesPerWord = 4;

`ifdef PROG_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        StIdle, StLenHi, StLenLo, StData, StChk, StDone, StErr
    } state_t;
`else
    typedef enum logic [2:0] {
        StIdle, StLenHi, StLenLo, StData, StDone, StErr
    } state_t;
`endif

endpackage

// File: rtl/byte_packer.sv
// Big-endian byte-to-word assembler: first byte lands in [31:24].
// word_valid pulses for one cycle after the 4th byte of a word is taken.
module byte_packer
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic [1:0]  byte_cnt,
    output logic [31:0] word,
    output logic        word_valid
);

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt   <= 2'd0;
            word       <= 32'd0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= in_valid && (byte_cnt == 2'(BytesPerWord - 1));
            if (in_valid) begin
                word     <= {word[23:0], in_byte};
                byte_cnt <= byte_cnt + 2'd1;
            end
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: length header, big-endian words into instruction memory.
// Optional trailing XOR checksum enabled by PROG_LOADER_CHECKSUM_EN.
module prog_loader
    import mips_pkg::*;
#(
    parameter int unsigned MAX_WORDS = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_reset,
    output logic        done,
    output logic        error
);

    state_t             state;
    logic [LenBits-1:0] len;
    logic [LenBits-1:0] word_cnt;
    logic               rx_ready_q;
    logic               done_q;
    logic               error_q;
    logic               cpu_reset_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]         xor_q;
`endif

    logic               accept;
    logic               data_accept;
    logic [1:0]         byte_cnt;
    logic [31:0]        word;
    logic               word_valid;
    logic [LenBits-1:0] len_next;
    logic               last_word;
    logic               last_byte;
    logic               last_write;

    assign accept      = rx_valid && rx_ready_q;
    assign data_accept = accept && (state == StData);
    assign len_next    = {len[15:8], rx_byte};
    assign last_word   = (word_cnt == len - 16'd1);
    assign last_byte   = data_accept && (byte_cnt == 2'd3) && last_word;
    assign last_write  = word_valid && last_word;

    byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (data_accept),
        .in_byte    (rx_byte),
        .byte_cnt   (byte_cnt),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= StIdle;
            len         <= '0;
            word_cnt    <= '0;
            rx_ready_q  <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cpu_reset_q <= 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            xor_q       <= 8'd0;
`endif
        end else begin
            case (state)
                StIdle: begin
                    if (start) begin
                        state      <= StLenHi;
                        rx_ready_q <= 1'b1;
                    end
                end
                StLenHi: begin
                    if (accept) begin
                        len[15:8] <= rx_byte;
                        state     <= StLenLo;
                    end
                end
                StLenLo: begin
                    if (accept) begin
                        len <= len_next;
                        if (len_next == '0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                            state <= StChk;
`else
                            state       <= StDone;
                            rx_ready_q  <= 1'b0;
                            done_q      <= 1'b1;
                            cpu_reset_q <= 1'b0;
`endif
                        end else if (32'(len_next) > MAX_WORDS) begin
                            state      <= StErr;
                            rx_ready_q <= 1'b0;
                            error_q    <= 1'b1;
                        end else begin
                            state <= StData;
                        end
                    end
                end
                StData: begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    if (data_accept) xor_q <= xor_q ^ rx_byte;
`endif
                    // Stop taking bytes once the final one is in; leave after its write.
                    if (last_byte) rx_ready_q <= 1'b0;
                    if (word_valid) word_cnt <= word_cnt + 16'd1;
                    if (last_write) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        state      <= StChk;
                        rx_ready_q <= 1'b1;
`else
                        state       <= StDone;
                        done_q      <= 1'b1;
                        cpu_reset_q <= 1'b0;
`endif
                    end
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                StChk: begin
                    if (accept) begin
                        rx_ready_q <= 1'b0;
                        if (rx_byte == xor_q) begin
                            state       <= StDone;
                            done_q      <= 1'b1;
                            cpu_reset_q <= 1'b0;
                        end else begin
                            state   <= StErr;
                            error_q <= 1'b1;
                        end
                    end
                end
`endif
                StDone, StErr: ;
                default: state <= StIdle;
            endcase
        end
    end

    assign rx_ready   = rx_ready_q;
    assign imem_we    = word_valid;
    assign imem_addr  = BASE_ADDR + {14'd0, word_cnt, 2'b00};
    assign imem_wdata = word;
    assign cpu_reset  = cpu_reset_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized scoreboard bench for prog_loader; honours PROG_LOADER_CHECKSUM_EN.
module tb_prog_loader;

`ifdef PROG_LOADER_CHECKSUM_EN
    localparam bit ChkEn = 1'b1;
`else
    localparam bit ChkEn = 1'b0;
`endif
    localparam int unsigned MaxWords = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_byte = 8'd0;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        done;
    logic        error;

    int n_checks = 0;
    int n_fail = 0;

    logic [63:0] exp_q[$];
    logic [7:0]  payload[$];

    always #5 clk = ~clk;

    prog_loader #(.MAX_WORDS(MaxWords), .BASE_ADDR(32'h0)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .rx_valid   (rx_valid),
        .rx_byte    (rx_byte),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .error      (error)
    );

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: every write must match the head of the scoreboard, with the core held in reset.
    always @(negedge clk) begin
        if (imem_we) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr=%h data=%h, expected no write",
                         imem_addr, imem_wdata);
            end else begin
                check("imem_write", {cpu_reset, imem_addr, imem_wdata},
                      {1'b1, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        rx_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer a byte until the loader takes it; returns after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap, output int stalls);
        bit taken = 1'b0;
        stalls = 0;
        repeat (gap) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
        for (int t = 0; t < 50 && !taken; t++) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_byte = b;
            if (rx_ready) begin
                taken = 1'b1;
                @(posedge clk);
            end else begin
                stalls++;
            end
        end
        if (!taken) check("byte_accept_timeout", 65'd0, 65'd1);
    endtask

    task automatic wait_end(input bit exp_ok);
        bit seen = 1'b0;
        @(negedge clk);
        rx_valid = 1'b0;
        for (int t = 0; t < 200 && !seen; t++) begin
            if (done || error) seen = 1'b1;
            else @(negedge clk);
        end
        check("done", 65'(done), 65'(exp_ok));
        check("error", 65'(error), 65'(!exp_ok));
        check("cpu_reset", 65'(cpu_reset), 65'(!exp_ok));
        repeat (2) @(negedge clk);
        check("pending_writes", 65'(exp_q.size()), 65'd0);
    endtask

    // Reference: a load is good iff the count fits and (when enabled) the checksum matches.
    task automatic run_load(input logic [15:0] len, input int mode, input bit corrupt);
        logic [7:0] x = 8'd0;
        int stalls;
        int data_stalls = 0;
        bit fits = (32'(len) <= MaxWords);
        bit exp_ok = fits && !(ChkEn && corrupt);
        int gap;
        if (fits) begin
            for (int k = 0; k < int'(len); k++)
                exp_q.push_back({32'(4 * k), payload[4*k], payload[4*k+1],
                                 payload[4*k+2], payload[4*k+3]});
        end
        pulse_start();
        send_byte(len[15:8], 0, stalls);
        send_byte(len[7:0], 0, stalls);
        if (fits) begin
            for (int i = 0; i < 4 * int'(len); i++) begin
                gap = (mode == 1) ? 1 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
                send_byte(payload[i], gap, stalls);
                data_stalls += stalls;
                x ^= payload[i];
            end
            if (ChkEn) send_byte(corrupt ? (x ^ 8'h01) : x, 0, stalls);
            if (mode == 0 && len != 0) check("no_bubbles", 65'(data_stalls), 65'd0);
            if (len == 0 && exp_ok) begin
                @(negedge clk);
                check("done_next_cycle", 65'(done), 65'd1);
            end
        end
        wait_end(exp_ok);
    endtask

    task automatic fill_payload(input int words);
        payload.delete();
        for (int i = 0; i < 4 * words; i++) payload.push_back(8'($urandom));
    endtask

    task automatic load_fixed();
        payload = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07};
    endtask

    initial begin
        int stalls;
        logic [15:0] n;

        do_reset();
        @(negedge clk);
        check("reset_rx_ready", 65'(rx_ready), 65'd0);
        check("reset_imem_we", 65'(imem_we), 65'd0);
        check("reset_done_error", 65'({done, error}), 65'd0);
        check("reset_cpu_reset", 65'(cpu_reset), 65'd1);

        // Bytes offered in IDLE must not be consumed.
        rx_valid = 1'b1;
        rx_byte = 8'hAA;
        repeat (4) @(negedge clk);
        check("idle_rx_ready", 65'(rx_ready), 65'd0);
        rx_valid = 1'b0;

        load_fixed();
        run_load(16'd2, 0, 1'b0);

        // start in DONE is ignored.
        pulse_start();
        repeat (2) @(negedge clk);
        check("done_sticky", 65'({done, rx_ready, cpu_reset}), 65'b100);

        do_reset();
        run_load(16'd0, 0, 1'b0);

        do_reset();
        run_load(16'h0101, 0, 1'b0);

        do_reset();
        payload = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_load(16'd1, 0, 1'b1);
        do_reset();
        run_load(16'd1, 0, 1'b0);

        do_reset();
        load_fixed();
        run_load(16'd2, 1, 1'b0);

        // Reset after the 6th byte: word 0 is already written, second load restarts at 0x0.
        do_reset();
        load_fixed();
        exp_q.push_back({32'h0, 32'h2008_0005});
        pulse_start();
        send_byte(8'h00, 0, stalls);
        send_byte(8'h02, 0, stalls);
        for (int i = 0; i < 4; i++) send_byte(payload[i], 0, stalls);
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("first_word_written", 65'(exp_q.size()), 65'd0);
        do_reset();
        @(negedge clk);
        check("midload_reset_state", 65'({rx_ready, done, error, cpu_reset}), 65'b0001);
        run_load(16'd2, 0, 1'b0);

        // Partial word abandoned by reset is never written.
        do_reset();
        pulse_start();
        send_byte(8'h00, 0, stalls);
        send_byte(8'h01, 0, stalls);
        send_byte(8'h11, 0, stalls);
        send_byte(8'h22, 0, stalls);
        do_reset();
        repeat (3) @(negedge clk);
        check("partial_abandoned", 65'({imem_we, rx_ready}), 65'd0);

        for (int it = 0; it < 12; it++) begin
            n = 16'($urandom_range(0, 6));
            if ($urandom_range(0, 5) == 0) n = 16'(257 + $urandom_range(0, 2000));
            fill_payload((32'(n) <= MaxWords) ? int'(n) : 0);
            do_reset();
            run_load(n, int'($urandom_range(0, 2)), ($urandom_range(0, 3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
